// File: rtl/fp_sqrt_arbiter_pkg.sv
// Shared types, FP32 constants and field helpers for the
// shared square-root arbiter.
package fp_sqrt_arbiter_pkg;

   localparam logic [31:0] FP32_QNAN     = 32'h7fc00000;
   localparam logic [7:0]  FP32_EXP_ALL1 = 8'hFF;
   localparam int          TAG_MAX_W     = 3;

   typedef struct packed {
      logic                 valid;
      logic [TAG_MAX_W-1:0] tag;
      logic [31:0]          data;
   } stage_t;

   function automatic logic fp32_sign(input logic [31:0] x);
      return x[31];
   endfunction

   function automatic logic [7:0] fp32_exp(input logic [31:0] x);
      return x[30:23];
   endfunction

   function automatic logic [22:0] fp32_man(input logic [31:0] x);
      return x[22:0];
   endfunction

   function automatic logic fp32_is_nan(input logic [31:0] x);
      return (fp32_exp(x) == FP32_EXP_ALL1) && (fp32_man(x) != '0);
   endfunction

endpackage

// File: rtl/fp_sqrt_arbiter_if.sv
// Requester-side operand and result handshakes of the
// shared square-root unit.
interface fp_sqrt_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ*32-1:0] req_data;
   logic [N_REQ-1:0]    req_ready;
   logic [N_REQ-1:0]    resp_valid;
   logic [N_REQ*32-1:0] resp_data;
   logic [N_REQ-1:0]    resp_ready;

   modport master (
      output req_valid, req_data, resp_ready,
      input  req_ready, resp_valid, resp_data
   );

   modport slave (
      input  req_valid, req_data, resp_ready,
      output req_ready, resp_valid, resp_data
   );
endinterface

// File: rtl/fp_sqrt_arbiter_rr.sv
// Round-robin arbiter: searches upward from the pointer,
// pointer moves past the winner when a grant is taken.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] eligible,
   input  logic         advance,
   output logic [N-1:0] grant,
   output logic [W-1:0] grant_idx
);

   logic [W-1:0] ptr;
   logic         found;

   always_comb begin
      int j;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      j         = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!found && eligible[j]) begin
            grant[j]  = 1'b1;
            grant_idx = W'(j);
            found     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         ptr <= '0;
      else if (advance)
         ptr <= (int'(grant_idx) == N-1) ? '0 : grant_idx + W'(1);
   end

endmodule

// File: rtl/fp_sqrt_arbiter_sqrt.sv
// Combinational IEEE-754 single square root, round to
// nearest even, subnormal inputs normalised first.
module fp_sqrt
   import fp_sqrt_arbiter_pkg::*;
(
   input  logic [31:0] a,
   output logic [31:0] y
);

   logic [7:0]  ef;
   logic [22:0] man;
   logic [23:0] sig;
   logic [24:0] madj;
   logic [49:0] rad;
   logic [27:0] rem;
   logic [27:0] trial;
   logic [24:0] root;
   logic [24:0] rnd;
   logic        inc;
   logic        found;
   int          ei;

   always_comb begin
      ef    = fp32_exp(a);
      man   = fp32_man(a);
      sig   = {1'b1, man};
      ei    = int'(ef) - 127;
      found = 1'b0;
      madj  = '0;
      rad   = '0;
      rem   = '0;
      trial = '0;
      root  = '0;
      rnd   = '0;
      inc   = 1'b0;
      y     = '0;
      if (ef == '0) begin
         for (int k = 22; k >= 0; k--) begin
            if (!found && man[k]) begin
               found = 1'b1;
               sig   = {man, 1'b0} << (22 - k);
               ei    = -126 - (23 - k);
            end
         end
      end
      // odd exponent: fold one factor of two into the radicand
      if (ei[0]) begin
         madj = {sig, 1'b0};
         ei   = ei - 1;
      end else begin
         madj = {1'b0, sig};
      end
      rad = {madj, 25'd0};
      for (int k = 24; k >= 0; k--) begin
         rem   = {rem[25:0], rad[2*k +: 2]};
         trial = {1'b0, root, 2'b01};
         if (rem >= trial) begin
            rem  = rem - trial;
            root = {root[23:0], 1'b1};
         end else begin
            root = {root[23:0], 1'b0};
         end
      end
      inc = root[0] & ((rem != '0) | root[1]);
      rnd = {1'b0, root[24:1]} + 25'(inc);
      if (fp32_is_nan(a))
         y = FP32_QNAN;
      else if (a[30:0] == '0)
         y = a;
      else if (fp32_sign(a))
         y = FP32_QNAN;
      else if (ef == FP32_EXP_ALL1)
         y = a;
      else
         y = {1'b0, 8'(ei / 2 + 127 + int'(rnd[24])),
              rnd[23] ? rnd[22:0] : 23'd0};
   end

endmodule

// File: rtl/fp_sqrt_arbiter.sv
// Shares one fp_sqrt among N_REQ requesters: round-robin
// issue, tagged pipeline, per-requester result slots.
module fp_sqrt_arbiter
   import fp_sqrt_arbiter_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int SQRT_LAT = 1,
   parameter int TAG_W    = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   fp_sqrt_arbiter_if.slave   bus,
   output logic [15:0]        nan_count,
   output logic               idle
);

   logic [N_REQ-1:0]    busy;
   logic [N_REQ-1:0]    elig;
   logic [N_REQ-1:0]    grant;
   logic [TAG_W-1:0]    gidx;
   logic [N_REQ-1:0]    rv;
   logic [N_REQ*32-1:0] rd;
   logic [31:0]         root;
   stage_t              s0;
   stage_t              sq;
   stage_t              ex;

   assign elig           = bus.req_valid & ~busy & {N_REQ{rst_n}};
   assign bus.req_ready  = grant;
   assign bus.resp_valid = rv;
   assign bus.resp_data  = rd;
   assign idle           = ~|busy;

   rr_arbiter #(
      .N (N_REQ),
      .W (TAG_W)
   ) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .eligible  (elig),
      .advance   (|grant),
      .grant     (grant),
      .grant_idx (gidx)
   );

   fp_sqrt u_sqrt (
      .a (s0.data),
      .y (root)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s0 <= '0;
      end else begin
         s0.valid <= |grant;
         s0.tag   <= TAG_MAX_W'(gidx);
         if (|grant)
            s0.data <= bus.req_data[32*gidx +: 32];
      end
   end

   assign sq = {s0.valid, s0.tag, root};

   // last stage of the latency budget is the result slot itself
   if (SQRT_LAT == 1) begin : g_direct
      assign ex = sq;
   end else begin : g_pipe
      stage_t pr [SQRT_LAT-1];
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            for (int k = 0; k < SQRT_LAT-1; k++)
               pr[k] <= '0;
         end else begin
            pr[0] <= sq;
            for (int k = 1; k < SQRT_LAT-1; k++)
               pr[k] <= pr[k-1];
         end
      end
      assign ex = pr[SQRT_LAT-2];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy      <= '0;
         rv        <= '0;
         rd        <= '0;
         nan_count <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (grant[i])
               busy[i] <= 1'b1;
            else if (rv[i] && bus.resp_ready[i])
               busy[i] <= 1'b0;
            if (ex.valid && ex.tag == TAG_MAX_W'(i)) begin
               rv[i]          <= 1'b1;
               rd[32*i +: 32] <= ex.data;
            end else if (rv[i] && bus.resp_ready[i]) begin
               rv[i] <= 1'b0;
            end
         end
         if (ex.valid && fp32_is_nan(ex.data) && nan_count != 16'hFFFF)
            nan_count <= nan_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_fp_sqrt_arbiter.sv
// Directed bench for fp_sqrt_arbiter, N_REQ=4, SQRT_LAT=1.
// Expected values are hand-derived constants.
module tb_fp_sqrt_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] nan_count;
   logic        idle;
   int          vecs = 0;
   int          errs = 0;

   fp_sqrt_arbiter_if #(.N_REQ(4)) bus ();

   fp_sqrt_arbiter #(
      .N_REQ    (4),
      .SQRT_LAT (1),
      .TAG_W    (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .nan_count (nan_count),
      .idle      (idle)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      bus.req_valid  = '0;
      bus.resp_ready = '0;
      step();
      rst_n = 1'b1;
   endtask

   logic [31:0] ops  [4] = '{32'h40800000, 32'h3f800000,
                             32'h3e800000, 32'h49742400};
   logic [31:0] roots[4] = '{32'h40000000, 32'h3f800000,
                             32'h3f000000, 32'h447a0000};
   logic [3:0]  rot  [10] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100,
                              4'b1000, 4'b0001, 4'b0100, 4'b1000,
                              4'b0001, 4'b0010};

   initial begin
      int cnt;
      rst_n          = 1'b0;
      bus.req_valid  = '0;
      bus.resp_ready = '0;
      bus.req_data   = '0;
      step();
      step();
      rst_n = 1'b1;
      #1;
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_rvalid", 32'(bus.resp_valid), 0);
      for (int i = 0; i < 4; i++)
         chk("rst_rdata", bus.resp_data[32*i +: 32], 0);
      chk("rst_nan", 32'(nan_count), 0);
      chk("rst_idle", 32'(idle), 1);

      // single request, two-cycle latency
      bus.req_data[31:0] = 32'h40000000;
      bus.req_valid      = 4'b0001;
      #1;
      chk("t1_grant", 32'(bus.req_ready), 32'h1);
      step();
      bus.req_valid = '0;
      chk("t1_idle_busy", 32'(idle), 0);
      chk("t1_early", 32'(bus.resp_valid), 0);
      step();
      chk("t1_rvalid", 32'(bus.resp_valid), 32'h1);
      chk("t1_sqrt2", bus.resp_data[31:0], 32'h3fb504f3);
      chk("t1_nan", 32'(nan_count), 0);
      bus.resp_ready = 4'b0001;
      step();
      bus.resp_ready = '0;
      chk("t1_consumed", 32'(bus.resp_valid), 0);
      chk("t1_idle", 32'(idle), 1);
      chk("t1_hold", bus.resp_data[31:0], 32'h3fb504f3);

      // all four at once
      do_reset();
      for (int i = 0; i < 4; i++)
         bus.req_data[32*i +: 32] = ops[i];
      bus.req_valid = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t2_grant", 32'(bus.req_ready), 32'(1 << k));
         step();
         bus.req_valid[k] = 1'b0;
      end
      chk("t2_partial", 32'(bus.resp_valid), 32'h7);
      step();
      chk("t2_rvalid", 32'(bus.resp_valid), 32'hf);
      for (int i = 0; i < 4; i++)
         chk("t2_root", bus.resp_data[32*i +: 32], roots[i]);
      bus.resp_ready = 4'b1111;
      step();
      bus.resp_ready = '0;
      chk("t2_drained", 32'(bus.resp_valid), 0);
      chk("t2_idle", 32'(idle), 1);

      // negative operand gives the canonical NaN
      bus.req_data[95:64] = 32'hbf800000;
      bus.req_valid       = 4'b0100;
      #1;
      chk("t3_grant", 32'(bus.req_ready), 32'h4);
      step();
      bus.req_valid = '0;
      step();
      chk("t3_rvalid", 32'(bus.resp_valid), 32'h4);
      chk("t3_qnan", bus.resp_data[95:64], 32'h7fc00000);
      chk("t3_nan", 32'(nan_count), 1);
      bus.resp_ready = 4'b0100;
      step();
      bus.resp_ready = '0;

      // requester 1 stalls on its result slot
      for (int i = 0; i < 4; i++)
         bus.req_data[32*i +: 32] = 32'h3f800000;
      bus.req_valid  = 4'b1111;
      bus.resp_ready = 4'b1101;
      for (int c = 0; c < 10; c++) begin
         if (c == 8) begin
            chk("t4_held", 32'(bus.resp_valid[1]), 1);
            chk("t4_held_data", bus.resp_data[63:32], 32'h3f800000);
            bus.resp_ready = 4'b1111;
         end
         #1;
         chk($sformatf("t4_rr%0d", c), 32'(bus.req_ready), 32'(rot[c]));
         step();
      end
      bus.req_valid  = '0;
      bus.resp_ready = 4'b1111;
      repeat (4) step();
      chk("t4_idle", 32'(idle), 1);
      chk("t4_rvalid", 32'(bus.resp_valid), 0);

      // saturation of the NaN counter
      for (int i = 0; i < 4; i++)
         bus.req_data[32*i +: 32] = 32'hbf800000;
      bus.req_valid = 4'b1111;
      cnt = 0;
      for (int c = 0; c < 70000 && cnt < 65536; c++) begin
         #1;
         if (|bus.req_ready)
            cnt++;
         step();
      end
      bus.req_valid = '0;
      chk("t5_grants", 32'(cnt), 65536);
      repeat (4) step();
      bus.resp_ready = '0;
      chk("t5_sat", 32'(nan_count), 32'hffff);
      chk("t5_idle", 32'(idle), 1);

      // reset with operands in flight
      for (int i = 0; i < 4; i++)
         bus.req_data[32*i +: 32] = 32'h3f800000;
      bus.req_valid = 4'b1111;
      repeat (3) step();
      chk("t6_inflight", 32'(idle), 0);
      bus.req_valid = '0;
      rst_n         = 1'b0;
      #1;
      chk("t6_rst_ready", 32'(bus.req_ready), 0);
      step();
      rst_n = 1'b1;
      chk("t6_rvalid", 32'(bus.resp_valid), 0);
      chk("t6_idle", 32'(idle), 1);
      chk("t6_nan", 32'(nan_count), 0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk("t6_stale", 32'(bus.resp_valid), 0);
      end
      bus.req_valid = 4'b1111;
      #1;
      chk("t6_first", 32'(bus.req_ready), 32'h1);
      step();
      bus.req_valid = '0;

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
